reg_bank_wr_arbiter: RTL



---
 rtl/reg_bank_wr_arbiter_pkg.sv | 15 +
 rtl/reg_bank_wr_arbiter_rr_pick.sv | 46 ++++
 rtl/reg_bank_wr_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/reg_bank_wr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_bank_wr_arbiter_pkg                                               |
// | Shared controller state encodings for the register-bank write arbiter |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package reg_bank_wr_arbiter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/reg_bank_wr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                               |
// | Combinational round-robin picker: first request at or after ptr wins  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [2*NREQ-1:0] w_req2;
  logic [2*NREQ-1:0] w_rot;
  logic [IW:0]       w_sum;

  // Rotating a doubled copy puts the requester at ptr in bit 0.
  assign w_req2 = {req, req};
  assign w_rot  = w_req2 >> ptr;

  always_comb begin
    w_sum   = '0;
    win_idx = '0;
    win     = '0;
    any     = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = {1'b0, ptr} + (IW + 1)'(k);
        if (w_sum >= (IW + 1)'(NREQ)) begin
          w_sum = w_sum - (IW + 1)'(NREQ);
        end
        win_idx = w_sum[IW-1:0];
      end
    end
    if (any) begin
      win[win_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_bank_wr_arbiter                                                   |
// | Round-robin shared write port into a small register bank, with a      |
// | registered read port and out-of-range write flag.                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module reg_bank_wr_arbiter
  import reg_bank_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  addr_err,
  output logic                  busy
);

  localparam int              c_IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0]     c_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [c_IW-1:0] c_LAST  = c_IW'(NREQ - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [c_IW-1:0]   r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic              r_err;
  logic [AW-1:0]     r_cap_addr;
  logic [WIDTH-1:0]  r_cap_data;
  logic [WIDTH-1:0]  r_bank [DEPTH];
  logic [WIDTH-1:0]  r_rd;

  logic [NREQ-1:0]   w_win;
  logic [c_IW-1:0]   w_win_idx;
  logic              w_any;
  logic              w_capture;
  logic              w_commit;
  logic              w_cap_ok;
  logic              w_rd_ok;
  logic [AW-1:0]     w_sel_addr;
  logic [WIDTH-1:0]  w_sel_data;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (c_IW)
  ) u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .win     (w_win),
    .win_idx (w_win_idx),
    .any     (w_any)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == ST_IDLE) && w_any;
    w_commit  = (r_state == ST_WRITE);
    busy      = w_commit;
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_sel_addr = wr_addr[i*AW +: AW];
        w_sel_data = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_cap_ok = ({1'b0, r_cap_addr} < c_DEPTH);
  assign w_rd_ok  = ({1'b0, rd_addr} < c_DEPTH);

  // Read samples the bank before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_err      <= 1'b0;
      r_rd       <= '0;
      r_cap_addr <= '0;
      r_cap_data <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        r_bank[d] <= '0;
      end
    end else begin
      r_rd  <= w_rd_ok ? r_bank[rd_addr] : '0;
      r_gnt <= w_capture ? w_win : '0;
      r_err <= w_commit && !w_cap_ok;
      if (w_capture) begin
        r_cap_addr <= w_sel_addr;
        r_cap_data <= w_sel_data;
        r_ptr      <= (w_win_idx == c_LAST) ? '0 : w_win_idx + 1'b1;
      end
      if (w_commit && w_cap_ok) begin
        r_bank[r_cap_addr] <= r_cap_data;
      end
    end
  end

  assign gnt      = r_gnt;
  assign addr_err = r_err;
  assign rd_data  = r_rd;

endmodule
`default_nettype wire
